// File: rtl/uart_tx_fifo_if.sv
// Producer/uart-facing bundle for the transmit FIFO.
// slave = the FIFO itself, master = whoever drives it (producer + uart side).
interface uart_tx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              clr_ovf;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              busy_tx;
  logic              transmit;
  logic [7:0]        data_tx;

  modport slave (
    input  wr_en, wr_data, clr_ovf, busy_tx,
    output full, empty, count, overflow, transmit, data_tx
  );

  modport master (
    output wr_en, wr_data, clr_ovf, busy_tx,
    input  full, empty, count, overflow, transmit, data_tx
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a uart transmitter: queues bursts from producers and
// issues one-cycle transmit pulses whenever the uart reports it is idle.
module uart_tx_fifo #(
  parameter int ADDR_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_fifo_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    WAIT_HI,
    WAIT_LO
  } state_t;

  logic [7:0]        mem [DEPTH];

  state_t            state_reg;
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic [ADDR_W:0]   count_next;
  logic              full_reg;
  logic              empty_reg;
  logic              overflow_reg;
  logic              transmit_reg;
  logic [7:0]        data_tx_reg;
  logic [1:0]        wait_cnt_reg;

  logic              push;
  logic              pop;

  // Both decisions use registered flags, so a same-cycle pop never frees
  // room for a write and a write into an empty FIFO is not popped until
  // the following cycle.
  assign push = bus.wr_en & ~full_reg;
  assign pop  = (state_reg == IDLE) & ~empty_reg & ~bus.busy_tx;

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + 1'b1;
    end else if (pop && !push) begin
      count_next = count_reg - 1'b1;
    end
  end

  // Read and write never hit the same entry in one cycle: a pop needs
  // count>0 and a push needs count<DEPTH, so equal pointers imply only one.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      full_reg     <= 1'b0;
      empty_reg    <= 1'b1;
      overflow_reg <= 1'b0;
      transmit_reg <= 1'b0;
      data_tx_reg  <= '0;
      wait_cnt_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_next;
      empty_reg <= (count_next == '0);
      full_reg  <= (count_next == FULL_CNT);

      if (bus.wr_en && full_reg) begin
        overflow_reg <= 1'b1;
      end else if (bus.clr_ovf) begin
        overflow_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (pop) begin
            transmit_reg <= 1'b1;
            data_tx_reg  <= mem[rd_ptr_reg];
            wait_cnt_reg <= '0;
            state_reg    <= WAIT_HI;
          end else begin
            transmit_reg <= 1'b0;
          end
        end
        WAIT_HI: begin
          transmit_reg <= 1'b0;
          // Give up after four cycles so a dead uart cannot stall the queue.
          if (bus.busy_tx) begin
            state_reg <= WAIT_LO;
          end else if (wait_cnt_reg == 2'd3) begin
            state_reg <= IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        WAIT_LO: begin
          transmit_reg <= 1'b0;
          if (!bus.busy_tx) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          transmit_reg <= 1'b0;
          state_reg    <= IDLE;
        end
      endcase
    end
  end

  assign bus.full     = full_reg;
  assign bus.empty    = empty_reg;
  assign bus.count    = count_reg;
  assign bus.overflow = overflow_reg;
  assign bus.transmit = transmit_reg;
  assign bus.data_tx  = data_tx_reg;

endmodule
